// File: rtl/depth_engine_stream_if.sv
// Valid/ready bundle for the escape-time engine: pixel coordinates in, depth results out.
// The engine uses the slave modport; the pixel generator / colour stage side uses master.
interface depth_engine_stream_if #(
    parameter int WORD_LENGTH = 32,
    parameter int ITER_W      = 10,
    parameter int TAG_W       = 20
);
    logic                          in_valid;
    logic                          in_ready;
    logic signed [WORD_LENGTH-1:0] in_re;
    logic signed [WORD_LENGTH-1:0] in_im;
    logic        [TAG_W-1:0]       in_tag;
    logic                          out_valid;
    logic                          out_ready;
    logic        [ITER_W-1:0]      out_depth;
    logic                          out_escaped;
    logic        [TAG_W-1:0]       out_tag;

    modport slave (
        input  in_valid, in_re, in_im, in_tag, out_ready,
        output in_ready, out_valid, out_depth, out_escaped, out_tag
    );

    modport master (
        output in_valid, in_re, in_im, in_tag, out_ready,
        input  in_ready, out_valid, out_depth, out_escaped, out_tag
    );
endinterface

// File: rtl/depth_engine_stream.sv
// Escape-time engine: iterates z <= z^2 + c in signed fixed point (Mandelbrot or Julia) and
// reports escape depth per pixel, three cycles (MUL, SUM, UPD) per iteration.
module depth_engine_stream #(
    parameter int WORD_LENGTH = 32,
    parameter int FRAC        = 28,
    parameter int ITER_W      = 10,
    parameter int TAG_W       = 20
) (
    input  logic                          sysclk,
    input  logic                          reset,
    input  logic                          abort_i,
    input  logic                          julia_mode_i,
    input  logic signed [WORD_LENGTH-1:0] julia_re_i,
    input  logic signed [WORD_LENGTH-1:0] julia_im_i,
    input  logic        [WORD_LENGTH-1:0] esc_r2_i,
    input  logic        [ITER_W-1:0]      max_iter_i,
    depth_engine_stream_if.slave          bus
);

    localparam int W  = WORD_LENGTH;
    localparam int PW = 2 * WORD_LENGTH;

    typedef enum logic [2:0] {IDLE, MUL, SUM, UPD, DONE} state_t;
    typedef logic signed [PW-1:0] wide_t;
    typedef logic signed [PW:0]   wider_t;

    state_t               state_q, state_d;
    logic signed [W-1:0]  re_q, re_d, im_q, im_d;
    logic signed [W-1:0]  cre_q, cre_d, cim_q, cim_d;
    logic        [W-1:0]  escr2_q, escr2_d;
    logic [ITER_W-1:0]    maxit_q, maxit_d, n_q, n_d;
    logic [TAG_W-1:0]     tag_q, tag_d;
    wide_t                re2_q, re2_d, im2_q, im2_d, reim_q, reim_d;
    logic                 esc_q, esc_d;
    logic [ITER_W-1:0]    depth_q, depth_d;
    logic                 escaped_q, escaped_d;
    logic [TAG_W-1:0]     otag_q, otag_d;

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            re_q      <= '0;
            im_q      <= '0;
            cre_q     <= '0;
            cim_q     <= '0;
            escr2_q   <= '0;
            maxit_q   <= '0;
            n_q       <= '0;
            tag_q     <= '0;
            re2_q     <= '0;
            im2_q     <= '0;
            reim_q    <= '0;
            esc_q     <= 1'b0;
            depth_q   <= '0;
            escaped_q <= 1'b0;
            otag_q    <= '0;
        end else begin
            state_q   <= state_d;
            re_q      <= re_d;
            im_q      <= im_d;
            cre_q     <= cre_d;
            cim_q     <= cim_d;
            escr2_q   <= escr2_d;
            maxit_q   <= maxit_d;
            n_q       <= n_d;
            tag_q     <= tag_d;
            re2_q     <= re2_d;
            im2_q     <= im2_d;
            reim_q    <= reim_d;
            esc_q     <= esc_d;
            depth_q   <= depth_d;
            escaped_q <= escaped_d;
            otag_q    <= otag_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        re_d      = re_q;
        im_d      = im_q;
        cre_d     = cre_q;
        cim_d     = cim_q;
        escr2_d   = escr2_q;
        maxit_d   = maxit_q;
        n_d       = n_q;
        tag_d     = tag_q;
        re2_d     = re2_q;
        im2_d     = im2_q;
        reim_d    = reim_q;
        esc_d     = esc_q;
        depth_d   = depth_q;
        escaped_d = escaped_q;
        otag_d    = otag_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    escr2_d = esc_r2_i;
                    maxit_d = max_iter_i;
                    tag_d   = bus.in_tag;
                    n_d     = '0;
                    if (julia_mode_i) begin
                        re_d  = bus.in_re;
                        im_d  = bus.in_im;
                        cre_d = julia_re_i;
                        cim_d = julia_im_i;
                    end else begin
                        re_d  = '0;
                        im_d  = '0;
                        cre_d = bus.in_re;
                        cim_d = bus.in_im;
                    end
                    state_d = MUL;
                end
            end
            MUL: begin
                re2_d   = wide_t'(re_q) * wide_t'(re_q);
                im2_d   = wide_t'(im_q) * wide_t'(im_q);
                reim_d  = wide_t'(re_q) * wide_t'(im_q);
                state_d = abort_i ? IDLE : SUM;
            end
            SUM: begin
                // Squares are non-negative, so the magnitude is compared unsigned in 2W+1 bits.
                esc_d   = ({1'b0, re2_q} + {1'b0, im2_q}) > ((PW+1)'(escr2_q) << FRAC);
                state_d = abort_i ? IDLE : UPD;
            end
            UPD: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (esc_q) begin
                    depth_d   = n_q;
                    escaped_d = 1'b1;
                    otag_d    = tag_q;
                    state_d   = DONE;
                end else if (n_q == maxit_q) begin
                    depth_d   = maxit_q;
                    escaped_d = 1'b0;
                    otag_d    = tag_q;
                    state_d   = DONE;
                end else begin
                    // Doubling re*im can overflow 2W bits at the most negative input, hence 2W+1.
                    re_d    = W'((re2_q - im2_q) >>> FRAC) + cre_q;
                    im_d    = W'((wider_t'(reim_q) <<< 1) >>> FRAC) + cim_q;
                    n_d     = n_q + ITER_W'(1);
                    state_d = MUL;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready    = (state_q == IDLE) & ~reset;
    assign bus.out_valid   = (state_q == DONE);
    assign bus.out_depth   = depth_q;
    assign bus.out_escaped = escaped_q;
    assign bus.out_tag     = otag_q;

endmodule

// File: tb/tb_depth_engine_stream.sv
// Directed bench for depth_engine_stream: hand-computed depths, latencies, backpressure,
// abort and mid-pixel reset behaviour.
module tb_depth_engine_stream;

    localparam logic [31:0] ZERO  = 32'h0000_0000;
    localparam logic [31:0] ONE   = 32'h1000_0000;
    localparam logic [31:0] THREE = 32'h3000_0000;
    localparam logic [31:0] FOUR  = 32'h4000_0000;
    localparam logic [31:0] MTWO  = 32'hE000_0000;

    logic        sysclk;
    logic        reset;
    logic        abort_i;
    logic        julia_mode;
    logic [31:0] julia_re;
    logic [31:0] julia_im;
    logic [31:0] esc_r2;
    logic [9:0]  max_iter;

    int errors = 0;
    int checks = 0;
    int cycles;
    int sawValid;

    depth_engine_stream_if #(.WORD_LENGTH(32), .ITER_W(10), .TAG_W(20)) bus ();

    depth_engine_stream #(
        .WORD_LENGTH(32),
        .FRAC(28),
        .ITER_W(10),
        .TAG_W(20)
    ) dut (
        .sysclk      (sysclk),
        .reset       (reset),
        .abort_i     (abort_i),
        .julia_mode_i(julia_mode),
        .julia_re_i  (julia_re),
        .julia_im_i  (julia_im),
        .esc_r2_i    (esc_r2),
        .max_iter_i  (max_iter),
        .bus         (bus)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic checkOutput(input string name, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", name, observed, expected);
        end
    endtask

    // Presents one pixel with its config and returns at the falling edge after the accept edge.
    task automatic applyStimulus(input logic jm, input logic [31:0] re, input logic [31:0] im,
                                 input logic [31:0] jre, input logic [31:0] jim,
                                 input logic [31:0] er2, input logic [9:0] mi,
                                 input logic [19:0] tag);
        @(negedge sysclk);
        julia_mode   = jm;
        julia_re     = jre;
        julia_im     = jim;
        esc_r2       = er2;
        max_iter     = mi;
        bus.in_re    = re;
        bus.in_im    = im;
        bus.in_tag   = tag;
        bus.in_valid = 1'b1;
        checkOutput("in_ready_before_accept", {63'd0, bus.in_ready}, 64'd1);
        @(posedge sysclk);
        @(negedge sysclk);
        bus.in_valid = 1'b0;
    endtask

    task automatic waitResult(output int n);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 2000) begin
            @(posedge sysclk);
            n++;
            @(negedge sysclk);
        end
    endtask

    task automatic checkResult(input string name, input int gotCycles, input int expCycles,
                               input logic [9:0] expDepth, input logic expEsc,
                               input logic [19:0] expTag);
        checkOutput({name, "_latency"}, 64'(gotCycles), 64'(expCycles));
        checkOutput({name, "_depth"}, {54'd0, bus.out_depth}, {54'd0, expDepth});
        checkOutput({name, "_escaped"}, {63'd0, bus.out_escaped}, {63'd0, expEsc});
        checkOutput({name, "_tag"}, {44'd0, bus.out_tag}, {44'd0, expTag});
        checkOutput({name, "_in_ready_done"}, {63'd0, bus.in_ready}, 64'd0);
    endtask

    task automatic handshake(input string name);
        bus.out_ready = 1'b1;
        @(posedge sysclk);
        @(negedge sysclk);
        bus.out_ready = 1'b0;
        checkOutput({name, "_valid_after_hs"}, {63'd0, bus.out_valid}, 64'd0);
        checkOutput({name, "_ready_after_hs"}, {63'd0, bus.in_ready}, 64'd1);
    endtask

    task automatic watchNoValid(input string name, input int n);
        sawValid = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge sysclk);
            if (bus.out_valid === 1'b1) sawValid = 1;
        end
        checkOutput({name, "_no_out_valid"}, 64'(sawValid), 64'd0);
    endtask

    initial begin
        reset         = 1'b1;
        abort_i       = 1'b0;
        julia_mode    = 1'b0;
        julia_re      = ZERO;
        julia_im      = ZERO;
        esc_r2        = FOUR;
        max_iter      = 10'd0;
        bus.in_valid  = 1'b0;
        bus.in_re     = ZERO;
        bus.in_im     = ZERO;
        bus.in_tag    = 20'd0;
        bus.out_ready = 1'b0;

        #12;
        checkOutput("reset_in_ready", {63'd0, bus.in_ready}, 64'd0);
        checkOutput("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
        checkOutput("reset_depth", {54'd0, bus.out_depth}, 64'd0);
        checkOutput("reset_escaped", {63'd0, bus.out_escaped}, 64'd0);
        checkOutput("reset_tag", {44'd0, bus.out_tag}, 64'd0);
        @(negedge sysclk);
        reset = 1'b0;
        #1;
        checkOutput("release_in_ready", {63'd0, bus.in_ready}, 64'd1);

        // c = 0 never leaves the origin: runs to max_iter
        $display("[TB] test 1: Mandelbrot c=0, max_iter=100");
        applyStimulus(1'b0, ZERO, ZERO, ZERO, ZERO, FOUR, 10'd100, 20'h00001);
        waitResult(cycles);
        checkResult("t1", cycles, 303, 10'd100, 1'b0, 20'h00001);
        handshake("t1");

        // c = 1+1i: z1 = 1+1i, z2 = 1+3i escapes; config changes after accept must be ignored
        $display("[TB] test 2: Mandelbrot c=1+1i with config changed mid-pixel");
        applyStimulus(1'b0, ONE, ONE, ZERO, ZERO, FOUR, 10'd50, 20'h00002);
        julia_mode = 1'b1;
        esc_r2     = 32'hFFFF_FFFF;
        max_iter   = 10'd0;
        waitResult(cycles);
        checkResult("t2", cycles, 9, 10'd2, 1'b1, 20'h00002);
        handshake("t2");

        $display("[TB] test 3: Julia z0=3, k=0 escapes immediately");
        applyStimulus(1'b1, THREE, ZERO, ZERO, ZERO, FOUR, 10'd50, 20'h00003);
        waitResult(cycles);
        checkResult("t3", cycles, 3, 10'd0, 1'b0 | 1'b1, 20'h00003);
        handshake("t3");

        $display("[TB] test 4: backpressure for 10 cycles");
        applyStimulus(1'b0, ONE, ONE, ZERO, ZERO, FOUR, 10'd50, 20'h00004);
        waitResult(cycles);
        checkResult("t4", cycles, 9, 10'd2, 1'b1, 20'h00004);
        for (int i = 0; i < 10; i++) begin
            @(posedge sysclk);
            @(negedge sysclk);
            checkOutput("t4_hold_valid", {63'd0, bus.out_valid}, 64'd1);
            checkOutput("t4_hold_depth", {54'd0, bus.out_depth}, 64'd2);
            checkOutput("t4_hold_tag", {44'd0, bus.out_tag}, 64'h00004);
            checkOutput("t4_hold_in_ready", {63'd0, bus.in_ready}, 64'd0);
        end
        abort_i = 1'b1;
        @(posedge sysclk);
        @(negedge sysclk);
        abort_i = 1'b0;
        checkOutput("t4_abort_in_done_valid", {63'd0, bus.out_valid}, 64'd1);
        checkOutput("t4_abort_in_done_escaped", {63'd0, bus.out_escaped}, 64'd1);
        handshake("t4");

        abort_i = 1'b1;
        @(posedge sysclk);
        @(negedge sysclk);
        abort_i = 1'b0;
        checkOutput("abort_in_idle_ready", {63'd0, bus.in_ready}, 64'd1);

        $display("[TB] test 5: abort during iteration");
        applyStimulus(1'b0, ZERO, ZERO, ZERO, ZERO, FOUR, 10'd100, 20'h00005);
        repeat (39) @(posedge sysclk);
        @(negedge sysclk);
        abort_i = 1'b1;
        @(posedge sysclk);
        @(negedge sysclk);
        abort_i = 1'b0;
        checkOutput("t5_ready_after_abort", {63'd0, bus.in_ready}, 64'd1);
        checkOutput("t5_valid_after_abort", {63'd0, bus.out_valid}, 64'd0);
        watchNoValid("t5", 350);
        applyStimulus(1'b0, ONE, ONE, ZERO, ZERO, FOUR, 10'd50, 20'h00015);
        waitResult(cycles);
        checkResult("t5_next", cycles, 9, 10'd2, 1'b1, 20'h00015);
        handshake("t5_next");

        // c = -2: z settles at 2 with |z|^2 = 4, which is not strictly above the radius
        $display("[TB] test 7: Mandelbrot c=-2 on the escape boundary");
        applyStimulus(1'b0, MTWO, ZERO, ZERO, ZERO, FOUR, 10'd5, 20'h00007);
        waitResult(cycles);
        checkResult("t7", cycles, 18, 10'd5, 1'b0, 20'h00007);
        handshake("t7");

        $display("[TB] test 8: max_iter=0 tests z0 once");
        applyStimulus(1'b0, ZERO, ZERO, ZERO, ZERO, FOUR, 10'd0, 20'h00008);
        waitResult(cycles);
        checkResult("t8", cycles, 3, 10'd0, 1'b0, 20'h00008);
        handshake("t8");

        $display("[TB] test 6: async reset pulse mid-SUM");
        applyStimulus(1'b0, ZERO, ZERO, ZERO, ZERO, FOUR, 10'd100, 20'h00006);
        @(posedge sysclk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t6_ready_in_reset", {63'd0, bus.in_ready}, 64'd0);
        checkOutput("t6_valid_in_reset", {63'd0, bus.out_valid}, 64'd0);
        @(negedge sysclk);
        @(negedge sysclk);
        reset = 1'b0;
        #1;
        checkOutput("t6_ready_after_release", {63'd0, bus.in_ready}, 64'd1);
        watchNoValid("t6", 350);
        applyStimulus(1'b1, THREE, ZERO, ZERO, ZERO, FOUR, 10'd50, 20'h00016);
        waitResult(cycles);
        checkResult("t6_next", cycles, 3, 10'd0, 1'b1, 20'h00016);
        handshake("t6_next");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
